// File: rtl/conv2_maxpool.sv
// conv2_maxpool: 2x2 stride-2 max-pool over a raster activation stream, half-row line buffer.
// Latency: a pooled value is valid the cycle after its window's bottom-right pixel is accepted.
// Backpressure: in_ready drops while the single output register is full and not being drained.
// Optional: define CONV2_MAXPOOL_ARGMAX_EN to add out_idx, the window position of the maximum.
module conv2_maxpool #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
`ifdef CONV2_MAXPOOL_ARGMAX_EN
   output logic [1:0]    out_idx,
`endif
   output logic          frame_done
);

   localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int LN = IMG_W / 2;
   localparam int LW = (LN > 1) ? $clog2(LN) : 1;
   localparam int NP = (IMG_W / 2) * (IMG_H / 2);
   localparam int PW = (NP > 1) ? $clog2(NP) : 1;

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [PW-1:0] PIX_LAST = PW'(NP - 1);

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [PW-1:0] pcnt;
   logic [DW-1:0] h_reg;
   logic [DW-1:0] linebuf [LN];
   logic [LW-1:0] lidx;
   logic [DW-1:0] lb_val;
   logic [DW-1:0] hmax;
   logic [DW-1:0] wmax;
   logic          h_right;
   logic          bot_wins;
   logic          in_fire;
   logic          out_fire;

   assign in_ready   = !clr && (!out_valid || out_ready);
   assign in_fire    = in_valid && in_ready;
   assign out_fire   = out_valid && out_ready;
   assign frame_done = out_fire && (pcnt == PIX_LAST);

   // Horizontal pair max; strict compare so a tie keeps the left (earlier) pixel.
   assign lidx     = LW'(col >> 1);
   assign lb_val   = linebuf[lidx];
   assign h_right  = (in_data > h_reg);
   assign hmax     = h_right ? in_data : h_reg;
   assign bot_wins = (hmax > lb_val);
   assign wmax     = bot_wins ? hmax : lb_val;

   // Raster counters, left-pixel holding register and the single output register.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         col       <= '0;
         row       <= '0;
         pcnt      <= '0;
         h_reg     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (out_fire) begin
            out_valid <= 1'b0;
            pcnt      <= (pcnt == PIX_LAST) ? '0 : pcnt + PW'(1);
         end
         if (in_fire) begin
            if (col == COL_LAST) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
            if (!col[0]) begin
               h_reg <= in_data;
            end else if (row[0]) begin
               out_data  <= wmax;
               out_valid <= 1'b1;
            end
         end
      end
   end

   // Top-row pair maxima, consumed by the odd row below; contents need no reset.
   always_ff @(posedge clk) begin
      if (!rst && in_fire && col[0] && !row[0]) begin
         linebuf[lidx] <= hmax;
      end
   end

`ifdef CONV2_MAXPOOL_ARGMAX_EN
   logic lb_w [LN];

   // Top-row winner bit per line-buffer entry (1 = top-right beat top-left).
   always_ff @(posedge clk) begin
      if (!rst && in_fire && col[0] && !row[0]) begin
         lb_w[lidx] <= h_right;
      end
   end

   // Window argmax; the top row wins ties, giving the lowest index.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         out_idx <= 2'd0;
      end else if (in_fire && col[0] && row[0]) begin
         out_idx <= bot_wins ? {1'b1, h_right} : {1'b0, lb_w[lidx]};
      end
   end
`endif

endmodule
